pipe_perf_counters: RTL and testbench

//  Hardware-side responder for pipeline statistics: counts cycles, data-hazard stalls, branch flushes and retired

---
 rtl/pipe_perf_counters_pkg.sv | 11 +
 rtl/pipe_perf_counters_sat_counter.sv | 20 ++
 rtl/pipe_perf_counters.sv | 74 +++++++
 tb/tb_pipe_perf_counters.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_perf_counters_pkg.sv
// pipe_perf_counters_pkg: register map, STATUS layout and responder FSM states
package pipe_perf_counters_pkg;
  localparam int PERF_CYCLE  = 0;
  localparam int PERF_STALL  = 1;
  localparam int PERF_FLUSH  = 2;
  localparam int PERF_RETIRE = 3;
  localparam int PERF_STATUS = 4;
  localparam int ST_START    = 0;
  localparam int ST_OVF      = 1;
  typedef enum logic {S_IDLE, S_RESP} state_e;
endpackage

// File: rtl/pipe_perf_counters_sat_counter.sv
// sat_counter: saturating event counter with clear priority and overflow-attempt pulse
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o,
  output logic         ovf_pulse_o
);
  logic [W-1:0] q_q, q_d;
  logic         full;
  assign full        = &q_q;
  assign ovf_pulse_o = en_i & ~clr_i & full;
  assign q_d         = clr_i ? '0 : (en_i & ~full) ? q_q + 1'b1 : q_q;
  assign q_o         = q_q;
  always_ff @(posedge clk_i)
    q_q <= rst_i ? '0 : q_d;
endmodule

// File: rtl/pipe_perf_counters.sv
// pipe_perf_counters: pipeline event counters served over a valid/ready read port
module pipe_perf_counters
  import pipe_perf_counters_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              flush_i,
  input  logic              retire_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [CNT_W-1:0]  rsp_data_o
);
  logic [3:0]             ev, ovf_pulse;
  logic [3:0]             ovf_q, ovf_d;
  logic [3:0][CNT_W-1:0]  cnt, snap_q;
  logic [CNT_W-1:0]       rd_data, status;
  logic                   accept, snap_hit;
  state_e                 state_q;
  assign ev = {retire_i, flush_i, stall_i & ~branch_i, 1'b1} & {4{start_i}};
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (ev[i]),
      .clr_i      (clear_i),
      .q_o        (cnt[i]),
      .ovf_pulse_o(ovf_pulse[i])
    );
  end
  assign ovf_d    = clear_i ? 4'b0 : ovf_q | ovf_pulse;
  assign accept   = req_valid_i & req_ready_o;
  assign snap_hit = req_addr_i == ADDR_W'(PERF_CYCLE);
  assign status   = CNT_W'({ovf_q, start_i});
  // An addr-0 read returns the live cycle count, which is exactly what lands in snap[0]
  always_comb begin
    rd_data = snap_hit                            ? cnt[PERF_CYCLE]
            : req_addr_i < ADDR_W'(PERF_STATUS)   ? snap_q[req_addr_i[1:0]]
            : req_addr_i == ADDR_W'(PERF_STATUS)  ? status
            : '0;
  end
  always_ff @(posedge clk_i) begin
    ovf_q  <= rst_i ? 4'b0 : ovf_d;
    snap_q <= rst_i ? '0 : (accept & snap_hit) ? cnt : snap_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else if (state_q == S_IDLE) begin
      if (req_valid_i) begin
        state_q     <= S_RESP;
        req_ready_o <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= rd_data;
      end
    end else if (rsp_ready_i) begin
      state_q     <= S_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_perf_counters.sv
// tb_pipe_perf_counters: directed scenarios plus random traffic against a behavioural model
module tb_pipe_perf_counters;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;
  logic clk = 0, rst = 1, start = 0, stall = 0, branch = 0, flush = 0, retire = 0, clear = 0;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [2:0] req_addr = 0;
  logic [W-1:0] rsp_data;
  int errors = 0, checks = 0;
  int m_cnt[4], m_snap[4];
  logic [3:0] m_ovf;
  bit m_busy;
  int m_data;
  logic [W-1:0] d, d0;

  pipe_perf_counters #(.CNT_W(W), .ADDR_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .clear_i(clear), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_addr_i(req_addr), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_read(input int a);
    if (a == 0) return m_cnt[0];
    if (a < 4) return m_snap[a];
    if (a == 4) return int'({m_ovf, start});
    return 0;
  endfunction

  task automatic step();
    bit e[4];
    if (rst) begin
      m_cnt = '{0, 0, 0, 0};
      m_snap = '{0, 0, 0, 0};
      m_ovf = 0;
      m_busy = 0;
      m_data = 0;
    end else begin
      if (req_valid && !m_busy) begin
        m_data = model_read(int'(req_addr));
        if (req_addr == 0) m_snap = m_cnt;
        m_busy = 1;
      end else if (m_busy && rsp_ready) m_busy = 0;
      e = '{1'b1, stall && !branch, flush, retire};
      if (clear) begin
        m_cnt = '{0, 0, 0, 0};
        m_ovf = 0;
      end else if (start)
        for (int i = 0; i < 4; i++)
          if (e[i]) begin
            if (m_cnt[i] == MAX) m_ovf[i] = 1'b1;
            else m_cnt[i]++;
          end
    end
    @(posedge clk);
    #1;
    chk("req_ready", req_ready, !m_busy);
    chk("rsp_valid", rsp_valid, m_busy);
    if (m_busy) chk("rsp_data", rsp_data, m_data);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [W-1:0] q);
    req_valid = 1; req_addr = a; rsp_ready = 0;
    step();
    req_valid = 0; rsp_ready = 1;
    q = rsp_data;
    step();
    rsp_ready = 0;
  endtask

  task automatic read_expect(input string name, input logic [2:0] a, input int exp);
    do_read(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    // reset with every strobe active
    {start, stall, flush, retire, clear, req_valid, rsp_ready} = '1;
    repeat (2) step();
    chk("reset_data", rsp_data, 0);
    rst = 0;
    {start, stall, flush, retire, clear, req_valid, rsp_ready} = '0;
    for (int a = 0; a < 5; a++) read_expect("reset_read", 3'(a), 0);
    // scenario 2: 10 running cycles
    start = 1;
    for (int i = 0; i < 10; i++) begin
      stall = i < 3; branch = i == 2; flush = i == 3 || i == 4; retire = i >= 5 && i <= 8;
      step();
    end
    {start, stall, branch, flush, retire} = '0;
    read_expect("count_cycle", 0, 10);
    read_expect("count_stall", 1, 2);
    read_expect("count_flush", 2, 2);
    read_expect("count_retire", 3, 4);
    // scenario 3: stopped CPU holds counts
    {stall, flush, retire} = '1;
    repeat (5) step();
    {stall, flush, retire} = '0;
    read_expect("hold_cycle", 0, 10);
    read_expect("hold_stall", 1, 2);
    read_expect("hold_retire", 3, 4);
    // scenario 4: saturate the cycle counter
    clear = 1; step(); clear = 0;
    start = 1;
    repeat (MAX + 3) step();
    read_expect("sat_cycle", 0, MAX);
    read_expect("sat_status", 4, 'h03);
    start = 0;
    read_expect("reserved", 6, 0);
    // scenario 5: snapshot isolation
    clear = 1; step(); clear = 0;
    read_expect("snap_zero", 0, 0);
    start = 1; stall = 1;
    repeat (7) step();
    start = 0; stall = 0;
    read_expect("snap_stale", 1, 0);
    read_expect("snap_refresh0", 0, 7);
    read_expect("snap_refresh1", 1, 7);
    // scenario 6: stall the response and clear underneath it
    req_valid = 1; req_addr = 1; rsp_ready = 0;
    step();
    req_valid = 0;
    d0 = rsp_data;
    chk("held_value", d0, 7);
    for (int i = 0; i < 4; i++) begin
      clear = i == 1;
      step();
      chk("held_stable", rsp_data, d0);
    end
    clear = 0; rsp_ready = 1; step(); rsp_ready = 0;
    read_expect("after_clear", 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 499) == 0;
      clear = $urandom_range(0, 399) == 0;
      start = $urandom_range(0, 7) != 0;
      {stall, branch, flush, retire} = 4'($urandom);
      req_valid = $urandom_range(0, 2) != 0;
      req_addr = 3'($urandom_range(0, 7));
      rsp_ready = $urandom_range(0, 2) != 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
